// File: rtl/traffic_pkg.sv
// Shared lane/arbiter types for the traffic request arbiter.
package traffic_pkg;
  localparam int NUM_LANES = 4;

  typedef logic [NUM_LANES-1:0] lane_vec_t;

  typedef enum logic [1:0] {
    LANE_A = 2'd0,
    LANE_B = 2'd1,
    LANE_C = 2'd2,
    LANE_D = 2'd3
  } lane_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;
endpackage

// File: rtl/traffic_req_arbiter_if.sv
// Sensor/light-controller bundle; emerg exists only with TRAFFIC_EMERGENCY_EN.
interface traffic_req_arbiter_if;
  import traffic_pkg::*;

  lane_vec_t sensor;
  lane_vec_t light_en;
  lane_vec_t switch_to;
  lane_vec_t pending;
`ifdef TRAFFIC_EMERGENCY_EN
  lane_vec_t emerg;

  modport master (output sensor, output light_en, output emerg, input switch_to, input pending);
  modport slave  (input sensor, input light_en, input emerg, output switch_to, output pending);
`else
  modport master (output sensor, output light_en, input switch_to, input pending);
  modport slave  (input sensor, input light_en, output switch_to, output pending);
`endif
endinterface

// File: rtl/traffic_debounce.sv
// One lane: 2-flop synchronizer, run-length debounce, registered rising-edge flag.
module traffic_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       r_sync1, r_sync2, r_level, r_level_q;
  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_async;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign o_rise = r_level & ~r_level_q;
endmodule

// File: rtl/traffic_req_arbiter.sv
// Round-robin lane request arbiter with latched pending flags.
// Optional emergency preemption under TRAFFIC_EMERGENCY_EN.
module traffic_req_arbiter
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  traffic_req_arbiter_if.slave bus
);
  lane_vec_t  w_rise, w_green, w_emerg, w_cand, w_rr_pick, w_emerg_pick;
  lane_vec_t  r_pending, r_grant, w_grant_nxt;
  arb_state_e r_state, w_state_nxt;
  lane_e      r_last, w_last_nxt, w_grant_lane;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    traffic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_async (bus.sensor[gi]),
      .o_rise  (w_rise[gi])
    );
  end

  // light_en is bit-reversed w.r.t. lane order; anything but one-hot means no lane green
  always_comb begin
    w_green = '0;
    for (int i = 0; i < NUM_LANES; i++)
      w_green[i] = $onehot(bus.light_en) & bus.light_en[NUM_LANES-1-i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= (r_pending | w_rise) & ~w_green;
  end

`ifdef TRAFFIC_EMERGENCY_EN
  lane_vec_t r_emerg_s1, r_emerg_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_emerg_s1 <= '0;
      r_emerg_s2 <= '0;
    end else begin
      r_emerg_s1 <= bus.emerg;
      r_emerg_s2 <= r_emerg_s1;
    end
  end
  assign w_emerg = r_emerg_s2;
`else
  assign w_emerg = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= LANE_D;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    logic [1:0] idx;
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_last_nxt   = r_last;
    w_cand       = r_pending & ~w_green;
    w_rr_pick    = '0;
    w_emerg_pick = '0;
    w_grant_lane = LANE_A;
    idx          = '0;
    // descending scan: the lane nearest after last_served is written last and wins
    for (int k = NUM_LANES; k >= 1; k--) begin
      idx = r_last + 2'(k);
      if (w_cand[idx]) w_rr_pick = lane_vec_t'(1) << idx;
    end
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (w_emerg[i]) w_emerg_pick = lane_vec_t'(1) << i;
    for (int i = 0; i < NUM_LANES; i++)
      if (r_grant[i]) w_grant_lane = lane_e'(2'(i));

    if (w_emerg_pick != '0 && r_grant != w_emerg_pick) begin
      w_state_nxt = ST_HOLD;
      w_grant_nxt = w_emerg_pick;
    end else begin
      case (r_state)
        ST_IDLE: if (w_rr_pick != '0) begin
          w_state_nxt = ST_HOLD;
          w_grant_nxt = w_rr_pick;
        end
        ST_HOLD: if ((r_grant & w_green) != '0) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_last_nxt  = w_grant_lane;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.switch_to = (r_state == ST_HOLD) ? r_grant : '0;
    bus.pending   = r_pending;
  end
endmodule

// File: tb/tb_traffic_req_arbiter.sv
// Directed bench with a per-cycle reference model of the lane arbiter.
module tb_traffic_req_arbiter;
  import traffic_pkg::*;

  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  traffic_req_arbiter_if bus();

  traffic_req_arbiter #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference model state (lane order: bit0 = A)
  lane_vec_t m_lvl, m_lvl_q, m_pend, m_grant;
  int        m_last;
  lane_vec_t m_hist[$];
  lane_vec_t m_ehist[$];

  task automatic check(input string name, input lane_vec_t act, input lane_vec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = '0; m_lvl_q = '0; m_pend = '0; m_grant = '0; m_last = 3;
    m_hist.delete();
    m_ehist.delete();
  endtask

  task automatic model_step();
    lane_vec_t green, rise, cand, g_n, lvl_n, esync;
    int  epick;
    bit  found, all_diff;
    green = '0;
    if ($countones(bus.light_en) == 1)
      for (int i = 0; i < 4; i++) green[i] = bus.light_en[3-i];
    rise  = m_lvl & ~m_lvl_q;
    esync = '0;
`ifdef TRAFFIC_EMERGENCY_EN
    if (m_ehist.size() >= 2) esync = m_ehist[1];
`endif
    g_n   = m_grant;
    epick = -1;
    for (int i = 3; i >= 0; i--) if (esync[i]) epick = i;
    if (epick >= 0 && m_grant != (4'b0001 << epick)) begin
      g_n = 4'b0001 << epick;
    end else if (m_grant == '0) begin
      cand  = m_pend & ~green;
      found = 1'b0;
      for (int k = 1; k <= 4; k++)
        if (!found && cand[(m_last + k) % 4]) begin
          found = 1'b1;
          g_n   = 4'b0001 << ((m_last + k) % 4);
        end
    end else if ((m_grant & green) != '0) begin
      g_n = '0;
      for (int i = 0; i < 4; i++) if (m_grant[i]) m_last = i;
    end
    // level flips once the last DC synchronized samples all disagree with it
    lvl_n = m_lvl;
    if (m_hist.size() > DC)
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= DC; j++) if (m_hist[j][i] == m_lvl[i]) all_diff = 1'b0;
        if (all_diff) lvl_n[i] = ~m_lvl[i];
      end
    m_pend  = (m_pend | rise) & ~green;
    m_grant = g_n;
    m_lvl_q = m_lvl;
    m_lvl   = lvl_n;
    m_hist.push_front(bus.sensor);
    if (m_hist.size() > DC + 2) void'(m_hist.pop_back());
`ifdef TRAFFIC_EMERGENCY_EN
    m_ehist.push_front(bus.emerg);
    if (m_ehist.size() > 3) void'(m_ehist.pop_back());
`endif
  endtask

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check("model_switch_to", bus.switch_to, m_grant);
    check("model_pending", bus.pending, m_pend);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input lane_vec_t s, input lane_vec_t l);
    rst_n = 1'b0;
    bus.sensor   = s;
    bus.light_en = l;
`ifdef TRAFFIC_EMERGENCY_EN
    bus.emerg = '0;
`endif
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_sw(input lane_vec_t exp, input int max_cyc, input string name);
    int n = 0;
    while (bus.switch_to !== exp && n < max_cyc) begin
      tick(1);
      n++;
    end
    check(name, bus.switch_to, exp);
  endtask

  initial begin
    bus.sensor   = '0;
    bus.light_en = '0;
`ifdef TRAFFIC_EMERGENCY_EN
    bus.emerg = '0;
`endif
    model_reset();

    // basic latency: B requested while A green
    do_reset(4'b0010, 4'b1000);
    check("reset_pending", bus.pending, 4'b0000);
    check("reset_switch", bus.switch_to, 4'b0000);
    tick(6);
    check("pend_edge6", bus.pending, 4'b0000);
    tick(1);
    check("pend_edge7", bus.pending, 4'b0010);
    check("sw_edge7", bus.switch_to, 4'b0000);
    tick(1);
    check("sw_edge8", bus.switch_to, 4'b0010);
    bus.light_en = 4'b0100;
    tick(1);
    check("sw_release_b", bus.switch_to, 4'b0000);
    check("pend_clear_b", bus.pending, 4'b0000);

    // 3-cycle glitch must be rejected
    do_reset(4'b0100, 4'b0000);
    tick(3);
    bus.sensor = 4'b0000;
    tick(12);
    check("glitch_pend", bus.pending, 4'b0000);
    check("glitch_sw", bus.switch_to, 4'b0000);

    // round robin B -> C -> D after A served
    do_reset(4'b0001, 4'b0000);
    wait_sw(4'b0001, 12, "rr_grant_a");
    bus.light_en = 4'b1000;
    tick(1);
    check("rr_release_a", bus.switch_to, 4'b0000);
    bus.sensor = 4'b1111;
    tick(7);
    check("rr_pend_bcd", bus.pending, 4'b1110);
    tick(1);
    check("rr_grant_b", bus.switch_to, 4'b0010);
    bus.light_en = 4'b0100;
    tick(1);
    check("rr_release_b", bus.switch_to, 4'b0000);
    check("rr_pend_cd", bus.pending, 4'b1100);
    tick(1);
    check("rr_grant_c", bus.switch_to, 4'b0100);
    bus.light_en = 4'b0010;
    tick(1);
    check("rr_release_c", bus.switch_to, 4'b0000);
    tick(1);
    check("rr_grant_d", bus.switch_to, 4'b1000);
    bus.light_en = 4'b0001;
    tick(1);
    check("rr_release_d", bus.switch_to, 4'b0000);
    check("rr_pend_none", bus.pending, 4'b0000);

    // request on the green lane clears immediately, never granted
    do_reset(4'b0001, 4'b1000);
    tick(12);
    check("green_pend", bus.pending, 4'b0000);
    check("green_sw", bus.switch_to, 4'b0000);

    // mid-grant async reset, then re-debounce
    do_reset(4'b0100, 4'b0000);
    tick(8);
    check("pre_rst_sw", bus.switch_to, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sw", bus.switch_to, 4'b0000);
    check("async_rst_pend", bus.pending, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick(7);
    check("regrant_edge7", bus.switch_to, 4'b0000);
    tick(1);
    check("regrant_edge8", bus.switch_to, 4'b0100);
    // multi-hot light_en: nobody green, grant and pending hold
    bus.light_en = 4'b0110;
    tick(3);
    check("multihot_sw", bus.switch_to, 4'b0100);
    check("multihot_pend", bus.pending, 4'b0100);
    bus.light_en = 4'b0010;
    tick(1);
    check("release_c", bus.switch_to, 4'b0000);
    check("release_c_pend", bus.pending, 4'b0000);

`ifdef TRAFFIC_EMERGENCY_EN
    do_reset(4'b0010, 4'b0000);
    wait_sw(4'b0010, 12, "em_normal_b");
    bus.emerg = 4'b1000;
    tick(1);
    bus.emerg = 4'b0000;
    tick(1);
    check("em_edge2", bus.switch_to, 4'b0010);
    tick(1);
    check("em_edge3", bus.switch_to, 4'b1000);
    bus.light_en = 4'b0001;
    tick(1);
    check("em_release_d", bus.switch_to, 4'b0000);
    tick(1);
    check("em_resume_b", bus.switch_to, 4'b0010);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/traffic_req_arbiter.md
TRAFFIC_REQ_ARBITER -- requirements
Module: traffic_req_arbiter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples (range 1..255) before a sensor level is accepted.
REQ-002 clk  input  1  clock; all flops rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sensor  input  4  raw asynchronous vehicle sensors; bit0=lane A … bit3=lane D.
REQ-005 light_en  input  4  one-hot green-lane indication from the downstream light controller; bit3=A … bit0=D.
REQ-006 switch_to  output  4  registered one-hot lane request to the light controller; bit0=A … bit3=D; 0 = no request.
REQ-007 pending  output  4  registered latched-request flags per lane, bit order as sensor.

Function
REQ-008 Each sensor bit SHALL pass a 2-flop synchronizer; sync output is the bit's value after the 2nd flop.
REQ-009 Per lane, a debounce counter SHALL count consecutive cycles where sync output differs from the debounced level, reset to 0 on any cycle they match, and update the debounced level when the count reaches DEBOUNCE_CYCLES.
REQ-010 Sensor held high from before edge 1: debounced=1 after edge 2+DEBOUNCE_CYCLES; pending set after edge 3+DEBOUNCE_CYCLES; switch_to asserted after edge 4+DEBOUNCE_CYCLES if the arbiter is idle.
REQ-011 pending[i] SHALL set on a rising edge of debounced[i] and clear on any cycle where lane i is green per light_en; clear wins over a simultaneous set.
REQ-012 Served-lane decoding: light_en not exactly one-hot (0000 or multi-hot) SHALL mean no lane green; no pending clears occur.
REQ-013 Arbiter states: IDLE (switch_to=0) and HOLD (switch_to one-hot, held constant).
REQ-014 IDLE->HOLD when any pending lane is not currently green; grant SHALL go to the first such lane in round-robin order starting after last_served (A->B->C->D->A).
REQ-015 HOLD->IDLE in the cycle after light_en shows the granted lane green; last_served SHALL then update to that lane.
REQ-016 A pending bit of the currently green lane SHALL never be granted.
REQ-017 switch_to SHALL change only on IDLE->HOLD, HOLD->IDLE, or emergency preemption (REQ-022); it SHALL never be multi-hot.

Reset
REQ-018 Reset SHALL clear synchronizers, debounced levels, counters, pending=0000, switch_to=0000, state=IDLE, last_served=D (first round-robin grant favours A).
REQ-019 Reset asserted mid-operation SHALL abort any held grant immediately; after release, a still-high sensor SHALL be re-debounced and re-latched per REQ-010.

Configuration
REQ-020 Macro TRAFFIC_EMERGENCY_EN SHALL control emergency preemption.
REQ-021 Defined: extra port emerg  input  4  asynchronous emergency requests, 2-flop synchronized, no debounce.
REQ-022 Defined: any synchronized emerg bit SHALL, next edge, force HOLD with switch_to = lowest-index asserted emerg lane (fixed priority A>B>C>D), replacing any normal grant; round-robin resumes after that lane is served.
REQ-023 Undefined: emerg port absent; behaviour is pure round-robin per REQ-013..017.

Structure
REQ-024 Package traffic_pkg SHALL hold NUM_LANES=4, lane index enum LANE_A..LANE_D, arbiter state enum, and the 4-bit lane vector typedef.
REQ-025 Sub-module traffic_debounce (synchronizer + counter + debounced level, one instance per lane) SHALL be used.

Verification
REQ-026 DEBOUNCE_CYCLES=4, sensor[1] high, light_en=1000 -> pending=0010 after edge 7, switch_to=0010 after edge 8.
REQ-027 sensor[2] glitch high 3 cycles then low -> pending and switch_to stay 0000.
REQ-028 pending=1110, last_served=A, lane A green -> grants B, then C, then D in order, each released the cycle after its light_en shows green.
REQ-029 pending[0] set while light_en=1000 (A green) -> pending[0] cleared, switch_to stays 0000.
REQ-030 TRAFFIC_EMERGENCY_EN defined, switch_to=0010 held, emerg=1000 -> switch_to=1000 three edges after emerg rises; after D served, normal grant to B resumes.
REQ-031 rst_n pulsed low while switch_to=0100 -> switch_to=0000, pending=0000 asynchronously; sensor[2] still high -> re-granted DEBOUNCE_CYCLES+4 edges after release.
